// File: rtl/memory_stage.sv
// memory_stage: EX/MEM register plus data-memory access over req/gnt/rvalid.
// Aligns store lanes, extends load data, flags misaligned and timed-out accesses.
module memory_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        valid_e,
    input  logic        reg_write_e,
    input  logic [1:0]  result_src_e,
    input  logic        mem_write_e,
    input  logic [2:0]  mem_size_e,
    input  logic [63:0] alu_result,
    input  logic [63:0] write_data,
    input  logic [4:0]  destination_register_e,
    input  logic [63:0] pc_plus4_e,
    output logic        stall_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_wstrb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [63:0] dmem_rdata,
    output logic        valid_m,
    output logic        reg_write_m,
    output logic [1:0]  result_src_m,
    output logic [63:0] alu_result_m,
    output logic [63:0] read_data_m,
    output logic [4:0]  destination_register_m,
    output logic [63:0] pc_plus4_m,
    output logic        misaligned_m,
    output logic        bus_error_m
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

    state_t      state;
    logic [7:0]  cnt;
    logic        q_reg_write;
    logic [1:0]  q_src;
    logic        q_store;
    logic [2:0]  q_size;
    logic [63:0] q_addr;
    logic [4:0]  q_rd;
    logic [63:0] q_pc;

    logic        is_mem;
    logic        misal;
    logic        misal_acc;
    logic [7:0]  strb_base;
    logic [63:0] lane;
    logic [63:0] load_ext;
    logic        timed_out;
    logic        fin;
    logic        fin_err;
    logic [63:0] fin_data;

    assign stall_m   = (state != S_IDLE);
    assign is_mem    = (result_src_e == 2'b01) | mem_write_e;
    assign misal_acc = is_mem & misal;
    assign timed_out = ((cnt + 8'd1) == TMO);

    always_comb begin
        misal     = 1'b0;
        strb_base = 8'h01;
        unique case (mem_size_e[1:0])
            2'b00: begin
                misal     = 1'b0;
                strb_base = 8'h01;
            end
            2'b01: begin
                misal     = alu_result[0];
                strb_base = 8'h03;
            end
            2'b10: begin
                misal     = |alu_result[1:0];
                strb_base = 8'h0f;
            end
            2'b11: begin
                misal     = |alu_result[2:0];
                strb_base = 8'hff;
            end
        endcase
    end

    always_comb begin
        lane     = dmem_rdata >> {q_addr[2:0], 3'b000};
        load_ext = lane;
        unique case (q_size)
            3'b000:  load_ext = {{56{lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{48{lane[15]}}, lane[15:0]};
            3'b010:  load_ext = {{32{lane[31]}}, lane[31:0]};
            3'b100:  load_ext = {56'd0, lane[7:0]};
            3'b101:  load_ext = {48'd0, lane[15:0]};
            3'b110:  load_ext = {32'd0, lane[31:0]};
            default: load_ext = lane;
        endcase
    end

    // Completion of an in-flight access: grant of a store, load data, or timeout.
    always_comb begin
        fin      = 1'b0;
        fin_err  = 1'b0;
        fin_data = 64'd0;
        unique case (state)
            S_REQ: begin
                if (dmem_gnt) begin
                    fin = q_store;
                end else if (timed_out) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            S_WAIT: begin
                if (dmem_rvalid) begin
                    fin      = 1'b1;
                    fin_data = load_ext;
                end else if (timed_out) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            default: begin
                fin = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                  <= S_IDLE;
            cnt                    <= 8'd0;
            q_reg_write            <= 1'b0;
            q_src                  <= 2'b00;
            q_store                <= 1'b0;
            q_size                 <= 3'b000;
            q_addr                 <= 64'd0;
            q_rd                   <= 5'd0;
            q_pc                   <= 64'd0;
            dmem_req               <= 1'b0;
            dmem_we                <= 1'b0;
            dmem_addr              <= 64'd0;
            dmem_wdata             <= 64'd0;
            dmem_wstrb             <= 8'd0;
            valid_m                <= 1'b0;
            reg_write_m            <= 1'b0;
            result_src_m           <= 2'b00;
            alu_result_m           <= 64'd0;
            read_data_m            <= 64'd0;
            destination_register_m <= 5'd0;
            pc_plus4_m             <= 64'd0;
            misaligned_m           <= 1'b0;
            bus_error_m            <= 1'b0;
        end else begin
            valid_m      <= 1'b0;
            misaligned_m <= 1'b0;
            bus_error_m  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (valid_e && (!is_mem || misal_acc)) begin
                        valid_m                <= 1'b1;
                        reg_write_m            <= reg_write_e & ~misal_acc;
                        result_src_m           <= result_src_e;
                        alu_result_m           <= alu_result;
                        read_data_m            <= 64'd0;
                        destination_register_m <= destination_register_e;
                        pc_plus4_m             <= pc_plus4_e;
                        misaligned_m           <= misal_acc;
                    end else if (valid_e) begin
                        q_reg_write <= reg_write_e;
                        q_src       <= result_src_e;
                        q_store     <= mem_write_e;
                        q_size      <= mem_size_e;
                        q_addr      <= alu_result;
                        q_rd        <= destination_register_e;
                        q_pc        <= pc_plus4_e;
                        dmem_req    <= 1'b1;
                        dmem_we     <= mem_write_e;
                        dmem_addr   <= {alu_result[63:3], 3'b000};
                        dmem_wdata  <= write_data << {alu_result[2:0], 3'b000};
                        dmem_wstrb  <= strb_base << alu_result[2:0];
                        cnt         <= 8'd0;
                        state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (dmem_gnt && !q_store) begin
                        dmem_req <= 1'b0;
                        state    <= S_WAIT;
                    end else if (!dmem_gnt && !timed_out) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_WAIT: begin
                    if (!dmem_rvalid && !timed_out) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
            if (fin) begin
                state                  <= S_IDLE;
                dmem_req               <= 1'b0;
                valid_m                <= 1'b1;
                reg_write_m            <= q_reg_write & ~fin_err;
                result_src_m           <= q_src;
                alu_result_m           <= q_addr;
                read_data_m            <= fin_data;
                destination_register_m <= q_rd;
                pc_plus4_m             <= q_pc;
                bus_error_m            <= fin_err;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: randomized and directed checks of memory_stage
// against a cycle-count reference model of the access protocol.
module tb_memory_stage;

    localparam int T = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid_e = 1'b0;
    logic        reg_write_e = 1'b0;
    logic [1:0]  result_src_e = 2'b00;
    logic        mem_write_e = 1'b0;
    logic [2:0]  mem_size_e = 3'b000;
    logic [63:0] alu_result = 64'd0;
    logic [63:0] write_data = 64'd0;
    logic [4:0]  destination_register_e = 5'd0;
    logic [63:0] pc_plus4_e = 64'd0;
    logic        stall_m;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [63:0] dmem_rdata = 64'd0;
    logic        valid_m;
    logic        reg_write_m;
    logic [1:0]  result_src_m;
    logic [63:0] alu_result_m;
    logic [63:0] read_data_m;
    logic [4:0]  destination_register_m;
    logic [63:0] pc_plus4_m;
    logic        misaligned_m;
    logic        bus_error_m;

    int checks = 0;
    int errors = 0;

    memory_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .valid_e(valid_e),
        .reg_write_e(reg_write_e),
        .result_src_e(result_src_e),
        .mem_write_e(mem_write_e),
        .mem_size_e(mem_size_e),
        .alu_result(alu_result),
        .write_data(write_data),
        .destination_register_e(destination_register_e),
        .pc_plus4_e(pc_plus4_e),
        .stall_m(stall_m),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb),
        .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata),
        .valid_m(valid_m),
        .reg_write_m(reg_write_m),
        .result_src_m(result_src_m),
        .alu_result_m(alu_result_m),
        .read_data_m(read_data_m),
        .destination_register_m(destination_register_m),
        .pc_plus4_m(pc_plus4_m),
        .misaligned_m(misaligned_m),
        .bus_error_m(bus_error_m)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Load result: take the addressed bytes, then extend by the size rule.
    function automatic logic [63:0] model_load(input logic [2:0] sz,
                                               input logic [2:0] off,
                                               input logic [63:0] rd);
        logic [63:0] v;
        logic [63:0] m;
        int nb;
        v  = rd >> (8 * int'(off));
        nb = 1 << sz[1:0];
        if (nb == 8) return v;
        m = (64'd1 << (8 * nb)) - 64'd1;
        v = v & m;
        if (!sz[2] && v[8*nb-1]) v = v | ~m;
        return v;
    endfunction

    task automatic junk_inputs();
        valid_e                = 1'b1;
        reg_write_e            = 1'($urandom);
        result_src_e           = 2'($urandom);
        mem_write_e            = 1'($urandom);
        mem_size_e             = 3'($urandom);
        alu_result             = rnd64();
        write_data             = rnd64();
        destination_register_e = 5'($urandom);
        pc_plus4_e             = rnd64();
    endtask

    // g: req cycle in which gnt is given; r: cycles from gnt to rvalid.
    task automatic run(input logic rw, input logic [1:0] src,
                       input logic mw, input logic [2:0] sz,
                       input logic [63:0] addr, input logic [63:0] wd,
                       input logic [4:0] rd, input logic [63:0] pc,
                       input int g, input int r, input logic [63:0] rdat);
        logic        is_mem, mis, err, is_load;
        int          nb, c, reqlast;
        logic [15:0] s16;
        logic [7:0]  exp_strb;
        logic [63:0] exp_wdata, exp_rdata;
        is_mem  = (src == 2'b01) || mw;
        is_load = is_mem && !mw;
        nb      = 1 << sz[1:0];
        mis     = is_mem && ((int'(addr[2:0]) % nb) != 0);
        err     = 1'b0;
        if (!is_mem || mis) begin
            c = 1; reqlast = 0;
        end else if (g > T) begin
            c = T + 1; reqlast = T; err = 1'b1;
        end else if (mw) begin
            c = g + 1; reqlast = g;
        end else if ((g - 1) + (r - 1) >= T) begin
            c = T + 2; reqlast = g; err = 1'b1;
        end else begin
            c = g + r + 1; reqlast = g;
        end
        s16       = ((16'd1 << nb) - 16'd1) << addr[2:0];
        exp_strb  = s16[7:0];
        exp_wdata = wd << (8 * int'(addr[2:0]));
        exp_rdata = (is_load && !mis && !err) ?
                    model_load(sz, addr[2:0], rdat) : 64'd0;

        @(negedge clock);
        valid_e                = 1'b1;
        reg_write_e            = rw;
        result_src_e           = src;
        mem_write_e            = mw;
        mem_size_e             = sz;
        alu_result             = addr;
        write_data             = wd;
        destination_register_e = rd;
        pc_plus4_e             = pc;
        dmem_gnt               = 1'b0;
        dmem_rvalid            = 1'b0;
        for (int k = 1; k <= c + 1; k++) begin
            @(negedge clock);
            chk("stall", stall_m, 64'(k < c));
            chk("req", dmem_req, 64'(k <= reqlast));
            if (k <= reqlast) begin
                chk("addr", dmem_addr, {addr[63:3], 3'b000});
                chk("we", dmem_we, 64'(mw));
                chk("wstrb", dmem_wstrb, 64'(exp_strb));
                if (mw) chk("wdata", dmem_wdata, exp_wdata);
            end
            chk("valid", valid_m, 64'(k == c));
            chk("misal", misaligned_m, 64'(k == c && mis));
            chk("berr", bus_error_m, 64'(k == c && err));
            if (k >= c) begin
                chk("rw_m", reg_write_m, 64'(rw && !mis && !err));
                chk("src_m", result_src_m, 64'(src));
                chk("alu_m", alu_result_m, addr);
                chk("rd_m", destination_register_m, 64'(rd));
                chk("pc_m", pc_plus4_m, pc);
                if (!mw && !err) chk("rdata_m", read_data_m, exp_rdata);
            end
            if (k < c) junk_inputs();
            else valid_e = 1'b0;
            dmem_gnt    = (k == g) && (k < c) && is_mem && !mis;
            dmem_rvalid = (k == g + r) && (k < c) && is_load;
            dmem_rdata  = (k == g + r) ? rdat : rnd64();
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        logic [63:0] a;
        logic [2:0]  sz;
        int          kind;
        repeat (2) @(negedge clock);
        chk("rst_stall", stall_m, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_valid", valid_m, 0);
        chk("rst_alu_m", alu_result_m, 0);
        chk("rst_strb", dmem_wstrb, 0);
        reset_n = 1'b1;

        run(1, 2'b00, 0, 3'b000, 64'h7, 64'h0, 5'd1, 64'h104, 1, 1, 64'h0);
        chk("alu_const", alu_result_m, 64'h7);
        run(0, 2'b00, 1, 3'b011, 64'h1000, 64'hDEADBEEFCAFEF00D, 5'd0,
            64'h108, 1, 1, 64'h0);
        run(1, 2'b01, 0, 3'b000, 64'h1003, 64'h0, 5'd5, 64'h10c, 1, 1,
            64'h0000000080000000);
        chk("lb_const", read_data_m, 64'hFFFFFFFFFFFFFF80);
        run(1, 2'b01, 0, 3'b100, 64'h1003, 64'h0, 5'd6, 64'h110, 1, 1,
            64'h0000000080000000);
        chk("lbu_const", read_data_m, 64'h80);
        run(0, 2'b00, 1, 3'b001, 64'h1006, 64'h1234, 5'd0, 64'h114, 1, 1,
            64'h0);
        run(1, 2'b01, 0, 3'b010, 64'h1002, 64'h0, 5'd7, 64'h118, 1, 1,
            64'h0);
        run(1, 2'b01, 0, 3'b011, 64'h2000, 64'h0, 5'd8, 64'h11c, 10, 1,
            64'h0);
        run(1, 2'b01, 0, 3'b011, 64'h2008, 64'h0, 5'd9, 64'h120, 1, 8,
            64'h0);
        run(0, 2'b00, 1, 3'b010, 64'h2010, 64'h55, 5'd0, 64'h124, 7, 1,
            64'h0);

        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 3));
            sz   = (kind == 3) ? 3'($urandom_range(0, 3))
                               : 3'($urandom_range(0, 6));
            a    = rnd64();
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz[1:0]) - 1);
            run(1'($urandom), (kind == 2) ? 2'b01 : (kind == 1) ? 2'b10 : 2'b00,
                kind == 3, sz, a, rnd64(), 5'($urandom), rnd64(),
                int'($urandom_range(1, 6)), int'($urandom_range(1, 4)),
                rnd64());
        end

        @(negedge clock);
        valid_e      = 1'b1;
        reg_write_e  = 1'b1;
        result_src_e = 2'b01;
        mem_write_e  = 1'b0;
        mem_size_e   = 3'b011;
        alu_result   = 64'h3000;
        @(negedge clock);
        valid_e  = 1'b0;
        dmem_gnt = 1'b1;
        @(negedge clock);
        dmem_gnt = 1'b0;
        chk("wait_stall", stall_m, 1);
        chk("wait_req", dmem_req, 0);
        reset_n = 1'b0;
        #1;
        chk("mrst_stall", stall_m, 0);
        chk("mrst_req", dmem_req, 0);
        chk("mrst_valid", valid_m, 0);
        chk("mrst_alu_m", alu_result_m, 0);
        chk("mrst_pc_m", pc_plus4_m, 0);
        chk("mrst_rw_m", reg_write_m, 0);
        @(negedge clock);
        reset_n     = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = rnd64();
        repeat (3) begin
            @(negedge clock);
            chk("late_rvalid", valid_m, 0);
            chk("late_stall", stall_m, 0);
        end
        dmem_rvalid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
